// File: rtl/ftdi_tx_arbiter.sv
// ftdi_tx_arbiter: round-robin packetiser in front of the FTDI 245-FIFO
// send stream. Each grant emits a {ch,len} header byte followed by len+1
// payload bytes; a stalled channel is padded out so framing never slips.
`timescale 1ns/1ps
module ftdi_tx_arbiter #(
  parameter int         NCH      = 4,
  parameter int         TIMEOUT  = 1024,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req_valid,
  input  logic [NCH*6-1:0] req_len,
  output logic [NCH-1:0]   req_ready,
  input  logic [NCH-1:0]   s_tvalid,
  output logic [NCH-1:0]   s_tready,
  input  logic [NCH*8-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [7:0]       m_tdata,
  output logic             timeout_err,
  output logic             busy
);

  // idle counter only needs to reach TIMEOUT-1
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA, PAD} state_t;

  state_t                 state;
  logic [1:0]             rr_ptr;
  logic [1:0]             ch;
  logic [5:0]             len;
  logic [5:0]             cnt;
  logic [IW-1:0]          idle_cnt;

  logic [1:0]             sel;
  logic [1:0]             sel_nxt;
  logic                   found;
  int                     idx;
  logic                   any_req;
  logic                   lane_valid;
  logic                   wd_fire;
  logic [NCH-1:0][7:0]    lane_data;
  logic [NCH-1:0][5:0]    lane_len;

  // per-channel slices viewed as packed lanes
  assign lane_data  = s_tdata;
  assign lane_len   = req_len;
  assign any_req    = |req_valid;
  assign lane_valid = s_tvalid[ch];

  // circular first-set search starting at rr_ptr
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr) + k) % NCH;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = 2'(idx);
      end
    end
    sel_nxt = (int'(sel) == NCH - 1) ? 2'd0 : sel + 2'd1;
  end

  // watchdog trips on the TIMEOUT-th consecutive empty cycle
  assign wd_fire = (TIMEOUT != 0) && (state == DATA) && !lane_valid &&
                   (idle_cnt == IW'(TIMEOUT - 1));

  // packet sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      ch       <= '0;
      len      <= '0;
      cnt      <= '0;
      idle_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (any_req) begin
          ch     <= sel;
          len    <= lane_len[sel];
          rr_ptr <= sel_nxt;
          state  <= HDR;
        end
        HDR: if (m_tready) begin
          cnt      <= len;
          idle_cnt <= '0;
          state    <= DATA;
        end
        DATA: begin
          if (lane_valid && m_tready) begin
            idle_cnt <= '0;
            if (cnt == 6'd0) state <= IDLE;
            else             cnt   <= cnt - 6'd1;
          end else if (!lane_valid) begin
            if (wd_fire) begin
              idle_cnt <= '0;
              state    <= PAD;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        PAD: if (m_tready) begin
          if (cnt == 6'd0) state <= IDLE;
          else             cnt   <= cnt - 6'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // output steering: header/pad from registered state, DATA is a pass-through
  always_comb begin
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    s_tready  = '0;
    req_ready = '0;
    unique case (state)
      IDLE: if (any_req && !rst) req_ready[sel] = 1'b1;
      HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = {ch, len};
      end
      DATA: begin
        m_tvalid     = lane_valid;
        m_tdata      = lane_data[ch];
        s_tready[ch] = m_tready;
      end
      PAD: begin
        m_tvalid = 1'b1;
        m_tdata  = PAD_BYTE;
      end
      default: ;
    endcase
  end

  assign timeout_err = wd_fire && !rst;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// tb_ftdi_tx_arbiter: directed packets with a byte scoreboard; stimulus
// pushes expected stream bytes, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ftdi_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [23:0] req_len = '0;
  logic [3:0]  req_ready;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tready;
  logic [31:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [7:0]  m_tdata;
  logic        timeout_err;
  logic        busy;

  always #5 clk = ~clk;

  ftdi_tx_arbiter #(.NCH(4), .TIMEOUT(8), .PAD_BYTE(8'h00)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .timeout_err(timeout_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait expired, got timeout expected event", name);
  endtask

  // scoreboard and per-channel byte sources
  logic [7:0] exp_q[$];
  logic [7:0] src_mem[4][16];
  int         src_rd[4] = '{default: 0};
  int         src_wr[4] = '{default: 0};
  logic [3:0] take = '0;
  bit         rdy_tog = 1'b0;

  always_comb begin
    s_tvalid = '0;
    s_tdata  = '0;
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i]       = src_rd[i] < src_wr[i];
      s_tdata[i*8 +: 8] = src_mem[i][src_rd[i] % 16];
    end
  end

  // advance sources on accepted bytes; optional m_tready toggling
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) if (take[i]) src_rd[i]++;
    m_tready = rdy_tog ? ~m_tready : 1'b1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  int         nxfer = 0, last_xfer_cyc = 0, gcnt = 0, tmo_cnt = 0, tmo_gap = 0;
  int         gcnt_ch[4] = '{default: 0};
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    take = s_tvalid & s_tready;
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", int'(m_tvalid), 1);
        check("hold_data", int'(m_tdata), int'(prev_data));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got 0x%0h expected no byte", m_tdata);
        end else begin
          check("sb_byte", int'(m_tdata), int'(exp_q.pop_front()));
        end
        nxfer++;
        last_xfer_cyc = cyc;
      end
      for (int i = 0; i < 4; i++) if (req_ready[i]) begin
        gcnt++;
        gcnt_ch[i]++;
      end
      if (timeout_err) begin
        tmo_cnt++;
        tmo_gap = cyc - last_xfer_cyc;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_src(input int c, input logic [7:0] b);
    src_mem[c][src_wr[c] % 16] = b;
    src_wr[c]++;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // raise a request, wait for its grant pulse, then drop it
  task automatic do_req(input int c, input int l);
    bit got;
    got = 1'b0;
    req_len[c*6 +: 6] = 6'(l);
    req_valid[c] = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (req_ready[c]) got = 1'b1;
    end
    if (!got) bound_fail("grant_wait");
    sync();
    req_valid[c] = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    if (!done) bound_fail(name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation hung");
  end

  initial begin
    int base, base2;
    bit got;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", int'(m_tvalid), 0);
    check("rst_m_tdata", int'(m_tdata), 0);
    check("rst_s_tready", int'(s_tready), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    check("rst_busy", int'(busy), 0);
    sync();
    rst = 1'b0;
    sync();

    // round robin: all channels, len=0, continuous requests
    exp_q = '{8'h00, 8'hA0, 8'h40, 8'hA1, 8'h80, 8'hA2, 8'hC0, 8'hA3, 8'h00, 8'hA4};
    push_src(0, 8'hA0); push_src(0, 8'hA4);
    push_src(1, 8'hA1); push_src(2, 8'hA2); push_src(3, 8'hA3);
    req_len = '0;
    base = gcnt;
    got = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (gcnt - base >= 5) got = 1'b1;
    end
    if (!got) bound_fail("rr_grants");
    sync();
    req_valid = '0;
    wait_idle("rr_done", 100);
    check("rr_grants_ch0", gcnt_ch[0], 2);
    check("rr_grants_ch3", gcnt_ch[3], 1);
    sync();

    // single packet ch1 len=2
    exp_q = '{8'h42, 8'h11, 8'h22, 8'h33};
    push_src(1, 8'h11); push_src(1, 8'h22); push_src(1, 8'h33);
    base = gcnt_ch[1];
    do_req(1, 2);
    wait_idle("single_done", 100);
    check("single_busy_drop", cyc - last_xfer_cyc, 1);
    check("single_req_ready_once", gcnt_ch[1] - base, 1);
    sync();

    // backpressure: toggling m_tready on ch2 len=3
    exp_q = '{8'h83, 8'h5A, 8'h6B, 8'h7C, 8'h8D};
    push_src(2, 8'h5A); push_src(2, 8'h6B); push_src(2, 8'h7C); push_src(2, 8'h8D);
    base = tmo_cnt;
    rdy_tog = 1'b1;
    do_req(2, 3);
    wait_idle("bp_done", 100);
    rdy_tog = 1'b0;
    check("bp_no_timeout", tmo_cnt - base, 0);
    sync();
    sync();

    // watchdog: ch0 len=4, only 2 bytes supplied
    exp_q = '{8'h04, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00};
    push_src(0, 8'h01); push_src(0, 8'h02);
    base = tmo_cnt;
    do_req(0, 4);
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (tmo_cnt != base) got = 1'b1;
    end
    if (!got) bound_fail("wd_fire");
    check("wd_fire_cycle", tmo_gap, 8);
    push_src(0, 8'h77);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      check("wd_pad_s_tready", int'(s_tready), 0);
      if (!busy) got = 1'b1;
    end
    if (!got) bound_fail("wd_pad_done");
    check("wd_sb_drained", exp_q.size(), 0);
    check("wd_single_pulse", tmo_cnt - base, 1);
    check("wd_late_byte_kept", src_wr[0] - src_rd[0], 1);
    sync();
    exp_q = '{8'h00, 8'h77};
    do_req(0, 0);
    wait_idle("late_done", 100);
    sync();

    // ch1 requests while ch0 is in DATA
    exp_q = '{8'h02, 8'h31, 8'h32, 8'h33};
    push_src(0, 8'h31); push_src(0, 8'h32); push_src(0, 8'h33);
    base = nxfer;
    do_req(0, 2);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (nxfer - base >= 1) got = 1'b1;
    end
    if (!got) bound_fail("sim_hdr");
    sync();
    req_len[11:6] = 6'd1;
    req_valid[1] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (req_ready[1]) got = 1'b1;
      else check("sim_no_early_tready1", int'(s_tready[1]), 0);
    end
    if (!got) bound_fail("sim_grant1");
    check("sim_ch0_done_first", nxfer - base, 4);
    check("sim_idle_gap", cyc - last_xfer_cyc, 1);
    exp_q.push_back(8'h41); exp_q.push_back(8'h44); exp_q.push_back(8'h45);
    push_src(1, 8'h44); push_src(1, 8'h45);
    sync();
    req_valid[1] = 1'b0;
    wait_idle("sim_done", 100);
    sync();

    // reset mid-DATA, then rr_ptr must be back at 0
    exp_q = '{8'h84, 8'h91};
    push_src(2, 8'h91);
    base = nxfer;
    do_req(2, 4);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (nxfer - base >= 2) got = 1'b1;
    end
    if (!got) bound_fail("rst_mid_bytes");
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_m_tvalid", int'(m_tvalid), 0);
    check("rstmid_m_tdata", int'(m_tdata), 0);
    check("rstmid_s_tready", int'(s_tready), 0);
    check("rstmid_timeout_err", int'(timeout_err), 0);
    check("rstmid_sb_drained", exp_q.size(), 0);
    sync();
    exp_q = '{8'h40, 8'hB1, 8'hC0, 8'hB3};
    push_src(1, 8'hB1); push_src(3, 8'hB3);
    req_len = '0;
    req_valid = 4'b1010;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) got = 1'b1;
    end
    if (!got) bound_fail("rstmid_grant");
    check("rstmid_first_grant", int'(req_ready), 4'b0010);
    sync();
    req_valid[1] = 1'b0;
    base2 = gcnt_ch[3];
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (gcnt_ch[3] != base2 || req_ready[3]) got = 1'b1;
    end
    if (!got) bound_fail("rstmid_grant3");
    sync();
    req_valid = '0;
    wait_idle("rstmid_done", 100);

    check("final_sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
